// File: rtl/demux1x8_tdm_receiver_if.sv
// Bus between the upstream 8x1 TDM mux side and the demux receiver.
//   master : drives din / din_valid / sync; observes s, y, out_valid, frame_err
//   slave  : the receiver (demux1x8_tdm_receiver)
interface demux1x8_tdm_receiver_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
);
    logic             din;
    logic             din_valid;
    logic             sync;
    logic [SEL_W-1:0] s;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             frame_err;

    modport master (
        output din, din_valid, sync,
        input  s, y, out_valid, frame_err
    );

    modport slave (
        input  din, din_valid, sync,
        output s, y, out_valid, frame_err
    );
endinterface

// File: rtl/demux1x8_tdm_receiver.sv
// Registered 1-to-WIDTH time-division demultiplexer (receive end of the 8x1 mux path).
// Each valid serial beat is stored at bit position [slot]; after WIDTH slots the
// reassembled word is presented on y with a one-cycle out_valid pulse. A sync beat
// marks slot 0; a sync arriving at a nonzero slot discards the partial word and
// pulses frame_err.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave modport: din, din_valid, sync in; s, y, out_valid, frame_err out
module demux1x8_tdm_receiver #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    demux1x8_tdm_receiver_if.slave    bus
);
    typedef enum logic {HUNT, RECV} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] slot_q,  slot_d;
    logic [WIDTH-1:0] asm_q,   asm_d;
    logic [WIDTH-1:0] y_q,     y_d;
    logic             ov_q,    ov_d;
    logic             fe_q,    fe_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            slot_q  <= '0;
            asm_q   <= '0;
            y_q     <= '0;
            ov_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            asm_q   <= asm_d;
            y_q     <= y_d;
            ov_q    <= ov_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        asm_d   = asm_q;
        y_d     = y_q;
        ov_d    = 1'b0;
        fe_d    = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (bus.din_valid && bus.sync) begin
                    asm_d    = '0;
                    asm_d[0] = bus.din;
                    slot_d   = SEL_W'(1);
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (bus.din_valid) begin
                    if (bus.sync && (slot_q != '0)) begin
                        // Resync: the beat carrying sync becomes slot 0 of a fresh word.
                        asm_d    = '0;
                        asm_d[0] = bus.din;
                        slot_d   = SEL_W'(1);
                        fe_d     = 1'b1;
                    end else begin
                        asm_d[slot_q] = bus.din;
                        // Natural SEL_W-bit overflow wraps the last slot back to 0.
                        slot_d = slot_q + SEL_W'(1);
                        if (slot_q == SEL_W'(WIDTH - 1)) begin
                            // asm_d already includes the final bit, so y never sees a partial word.
                            y_d  = asm_d;
                            ov_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    assign bus.s         = slot_q;
    assign bus.y         = y_q;
    assign bus.out_valid = ov_q;
    assign bus.frame_err = fe_q;
endmodule

// File: tb/tb_demux1x8_tdm_receiver.sv
module tb_demux1x8_tdm_receiver;
    localparam int WIDTH = 8;
    localparam int SEL_W = 3;

    logic clk;
    logic rst;

    demux1x8_tdm_receiver_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    demux1x8_tdm_receiver #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a list of received bits; s is simply how many bits are held.
    bit             m_hunting = 1'b1;
    bit             m_bits[$];
    logic [WIDTH-1:0] m_y  = '0;
    bit             m_ov = 1'b0;
    bit             m_fe = 1'b0;

    function automatic void model_reset();
        m_hunting = 1'b1;
        m_bits.delete();
        m_y  = '0;
        m_ov = 1'b0;
        m_fe = 1'b0;
    endfunction

    function automatic void model_step(input bit v, input bit sy, input bit d);
        logic [WIDTH-1:0] w;
        m_ov = 1'b0;
        m_fe = 1'b0;
        if (!v) return;
        if (m_hunting) begin
            if (sy) begin
                m_hunting = 1'b0;
                m_bits.delete();
                m_bits.push_back(d);
            end
        end else if (sy && m_bits.size() != 0) begin
            m_fe = 1'b1;
            m_bits.delete();
            m_bits.push_back(d);
        end else begin
            m_bits.push_back(d);
            if (m_bits.size() == WIDTH) begin
                w = '0;
                for (int k = 0; k < WIDTH; k++) w[k] = m_bits[k];
                m_y  = w;
                m_ov = 1'b1;
                m_bits.delete();
            end
        end
    endfunction

    function automatic logic [SEL_W-1:0] model_s();
        return m_hunting ? '0 : SEL_W'(m_bits.size());
    endfunction

    // Every-cycle comparison against the model, plus pulse bookkeeping.
    bit cmp_en = 1'b0;
    int cyc = 0;
    int ov_cnt = 0;
    int fe_cnt = 0;
    int last_ov = 0;
    int prev_ov = 0;

    always @(negedge clk) begin
        cyc++;
        if (cmp_en && !rst) begin
            chk("s",         32'(bus.s),         32'(model_s()));
            chk("y",         32'(bus.y),         32'(m_y));
            chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
            chk("frame_err", 32'(bus.frame_err), 32'(m_fe));
            if (bus.out_valid) begin
                ov_cnt++;
                prev_ov = last_ov;
                last_ov = cyc;
            end
            if (bus.frame_err) fe_cnt++;
        end
    end

    task automatic cycle(input bit v, input bit sy, input bit d);
        @(negedge clk);
        bus.din_valid = v;
        bus.sync      = sy;
        bus.din       = d;
        @(posedge clk);
        model_step(v, sy, d);
    endtask

    task automatic send_bits(input logic [WIDTH-1:0] w, input int first, input int last, input bit sync_first);
        for (int i = first; i <= last; i++)
            cycle(1'b1, sync_first && (i == first), w[i]);
    endtask

    task automatic settle();
        #1;
    endtask

    int ov_base;
    int fe_base;

    initial begin
        rst = 1'b1;
        bus.din = 1'b0;
        bus.din_valid = 1'b0;
        bus.sync = 1'b0;
        #12;
        chk("reset_y",  32'(bus.y), 32'h0);
        chk("reset_s",  32'(bus.s), 32'h0);
        chk("reset_ov", 32'(bus.out_valid), 32'h0);
        chk("reset_fe", 32'(bus.frame_err), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Single frame A5
        ov_base = ov_cnt;
        send_bits(8'hA5, 0, 7, 1'b1);
        settle();
        chk("t1_y",  32'(bus.y), 32'hA5);
        chk("t1_ov", 32'(bus.out_valid), 32'h1);
        chk("t1_s",  32'(bus.s), 32'h0);
        chk("t1_fe", 32'(bus.frame_err), 32'h0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t1_pulses", 32'(ov_cnt - ov_base), 32'd1);

        // A5 with a 3-cycle gap between slots 3 and 4
        ov_base = ov_cnt;
        send_bits(8'hA5, 0, 3, 1'b1);
        for (int g = 0; g < 3; g++) begin
            cycle(1'b0, 1'b0, 1'b0);
            settle();
            chk("t2_gap_s", 32'(bus.s), 32'd4);
        end
        send_bits(8'hA5, 4, 7, 1'b0);
        settle();
        chk("t2_y",  32'(bus.y), 32'hA5);
        chk("t2_ov", 32'(bus.out_valid), 32'h1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t2_pulses", 32'(ov_cnt - ov_base), 32'd1);

        // Back-to-back 3C, C3
        send_bits(8'h3C, 0, 7, 1'b1);
        settle();
        chk("t3_y0", 32'(bus.y), 32'h3C);
        send_bits(8'hC3, 0, 7, 1'b1);
        settle();
        chk("t3_y1", 32'(bus.y), 32'hC3);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t3_spacing", 32'(last_ov - prev_ov), 32'd8);

        // Resync at slot 5, new frame 81
        fe_base = fe_cnt;
        send_bits(8'hFF, 0, 4, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        settle();
        chk("t4_fe", 32'(bus.frame_err), 32'h1);
        chk("t4_ov", 32'(bus.out_valid), 32'h0);
        chk("t4_y_hold", 32'(bus.y), 32'hC3);
        chk("t4_s", 32'(bus.s), 32'd1);
        send_bits(8'h81, 1, 7, 1'b0);
        settle();
        chk("t4_y", 32'(bus.y), 32'h81);
        chk("t4_ov_end", 32'(bus.out_valid), 32'h1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t4_fe_pulses", 32'(fe_cnt - fe_base), 32'd1);

        // HUNT ignores unsynced beats and sync without valid
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        ov_base = ov_cnt;
        fe_base = fe_cnt;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, i[0]);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        settle();
        chk("t5_ov_cnt", 32'(ov_cnt - ov_base), 32'd0);
        chk("t5_fe_cnt", 32'(fe_cnt - fe_base), 32'd0);
        chk("t5_s", 32'(bus.s), 32'd0);
        chk("t5_y", 32'(bus.y), 32'h0);

        // Asynchronous reset mid-frame, then 5A
        send_bits(8'h77, 0, 4, 1'b1);
        send_bits(8'h77, 0, 2, 1'b1);
        send_bits(8'h77, 3, 7, 1'b0);
        settle();
        chk("t6_pre_y", 32'(bus.y), 32'h77);
        send_bits(8'hFF, 0, 4, 1'b1);
        #2;
        bus.din_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rst_y",  32'(bus.y), 32'h0);
        chk("t6_rst_s",  32'(bus.s), 32'h0);
        chk("t6_rst_ov", 32'(bus.out_valid), 32'h0);
        chk("t6_rst_fe", 32'(bus.frame_err), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        ov_base = ov_cnt;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1);
        settle();
        chk("t6_nosync_ov", 32'(ov_cnt - ov_base), 32'd0);
        chk("t6_nosync_s", 32'(bus.s), 32'd0);
        send_bits(8'h5A, 0, 7, 1'b1);
        settle();
        chk("t6_y",  32'(bus.y), 32'h5A);
        chk("t6_ov", 32'(bus.out_valid), 32'h1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
